// File: rtl/row_stream_tx_pkg.sv
// Shared types and constants for the row-buffer transmit path.
// The default idle gap is derived from the row-buffer's SRAM wait length.
package row_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } rd_state_e;

    localparam int K_DEFAULT          = 3;
    localparam int SRAM_WORD_DEFAULT  = 256;
    localparam int SRAM_WIDTH_DEFAULT = 8;
    localparam int NUM_ROWS_DEFAULT   = 224;

    // One cycle for the row-buffer to see in_valid low, plus its SRAM wait.
    localparam int RB_SRAM_WAIT = 3;
    localparam int GAP_DEFAULT  = RB_SRAM_WAIT + 1;

    function automatic int col_width(input int k, input int sram_width);
        return k * sram_width;
    endfunction

    localparam int COL_W_DEFAULT = col_width(K_DEFAULT, SRAM_WIDTH_DEFAULT);

endpackage

// File: rtl/row_stream_tx_if.sv
// Upstream word handshake and row-buffer burst signals of row_stream_tx.
// master is the transmitter's view, slave the view of its environment.
interface row_stream_tx_if
    import row_stream_tx_pkg::*;
#(
    parameter int W = COL_W_DEFAULT
);
    logic         up_valid;
    logic [W-1:0] up_data;
    logic         up_ready;
    logic         tx_valid;
    logic [W-1:0] DATAOUT;
    logic         row_done;
    logic         frame_done;

    modport master (
        input  up_valid,
        input  up_data,
        output up_ready,
        output tx_valid,
        output DATAOUT,
        output row_done,
        output frame_done
    );

    modport slave (
        output up_valid,
        output up_data,
        input  up_ready,
        input  tx_valid,
        input  DATAOUT,
        input  row_done,
        input  frame_done
    );
endinterface

// File: rtl/row_pingpong_store.sv
// Two-bank row store with per-bank full flags and write/read bank pointers.
// The RAM itself is not reset; only flags, pointers and the read register are.
module row_pingpong_store #(
    parameter int W     = 24,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_fill,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          rd_release,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          full_wr,
    output logic          full_rd
);

    logic [W-1:0] bank_mem [2][DEPTH];

    logic [1:0]   full_q, full_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [W-1:0] rd_data_q, rd_data_d;

    // Fill sets the write bank's flag, release clears the read bank's flag;
    // the writer never targets a full bank so the two never collide.
    always_comb begin
        full_d[0] = (wr_fill && !wr_bank_q) ? 1'b1
                  : ((rd_release && !rd_bank_q) ? 1'b0 : full_q[0]);
        full_d[1] = (wr_fill && wr_bank_q) ? 1'b1
                  : ((rd_release && rd_bank_q) ? 1'b0 : full_q[1]);
        wr_bank_d = wr_bank_q ^ wr_fill;
        rd_bank_d = rd_bank_q ^ rd_release;
        rd_data_d = rd_en ? bank_mem[rd_bank_q][rd_addr] : rd_data_q;
    end

    // Flag, pointer and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_mem[wr_bank_q][wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;
    assign full_wr = full_q[wr_bank_q];
    assign full_rd = full_q[rd_bank_q];

endmodule

// File: rtl/row_stream_tx.sv
// Collects rows of column words into a ping-pong store and replays each row
// as a gap-free burst to the row-buffer, followed by a fixed idle gap.
module row_stream_tx
    import row_stream_tx_pkg::*;
#(
    parameter int K          = K_DEFAULT,
    parameter int SRAM_WORD  = SRAM_WORD_DEFAULT,
    parameter int SRAM_WIDTH = SRAM_WIDTH_DEFAULT,
    parameter int GAP        = GAP_DEFAULT,
    parameter int NUM_ROWS   = NUM_ROWS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    row_stream_tx_if.master bus
);

    localparam int W  = col_width(K, SRAM_WIDTH);
    localparam int AW = $clog2(SRAM_WORD);
    localparam int GW = $clog2(GAP + 1);
    localparam int RW = $clog2(NUM_ROWS);

    localparam logic [AW-1:0] LAST_ADDR = AW'(SRAM_WORD - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);

    logic          run_q, run_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_en, wr_fill;
    logic          full_wr, full_rd;

    rd_state_e     state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          tx_valid_q, tx_valid_d;
    logic          row_done_q, row_done_d;
    logic          frame_done_q, frame_done_d;

    logic          rd_en, rd_release;
    logic [AW-1:0] rd_addr_s;
    logic [W-1:0]  rd_data;

    // run_q keeps up_ready low through reset and rises on the first clock after.
    assign bus.up_ready = run_q && !full_wr;

    // Write-side address: advance on handshake, wrap when the row completes.
    always_comb begin
        run_d   = 1'b1;
        wr_en   = bus.up_valid && bus.up_ready;
        wr_fill = wr_en && (wr_addr_q == LAST_ADDR);
        if (wr_fill) begin
            wr_addr_d = '0;
        end else if (wr_en) begin
            wr_addr_d = wr_addr_q + AW'(1);
        end else begin
            wr_addr_d = wr_addr_q;
        end
    end

    // Write-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            run_q     <= run_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Read FSM next state. rd_addr_q is the address of the beat on DATAOUT,
    // so the store is read one address ahead to keep the burst contiguous.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        gap_cnt_d    = gap_cnt_q;
        row_cnt_d    = row_cnt_q;
        tx_valid_d   = tx_valid_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        rd_en        = 1'b0;
        rd_release   = 1'b0;
        rd_addr_s    = rd_addr_q + AW'(1);
        case (state_q)
            ST_IDLE: begin
                if (full_rd) begin
                    rd_en      = 1'b1;
                    rd_addr_s  = '0;
                    rd_addr_d  = '0;
                    tx_valid_d = 1'b1;
                    state_d    = ST_BURST;
                end else begin
                    tx_valid_d = 1'b0;
                end
            end
            ST_BURST: begin
                if (rd_addr_q == LAST_ADDR) begin
                    rd_release   = 1'b1;
                    tx_valid_d   = 1'b0;
                    gap_cnt_d    = '0;
                    row_done_d   = 1'b1;
                    frame_done_d = (row_cnt_q == LAST_ROW);
                    row_cnt_d    = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + RW'(1);
                    state_d      = ST_GAP;
                end else begin
                    rd_en     = 1'b1;
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Read FSM state, counters and registered burst outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            gap_cnt_q    <= '0;
            row_cnt_q    <= '0;
            tx_valid_q   <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            gap_cnt_q    <= gap_cnt_d;
            row_cnt_q    <= row_cnt_d;
            tx_valid_q   <= tx_valid_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    row_pingpong_store #(
        .W     (W),
        .DEPTH (SRAM_WORD),
        .AW    (AW)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_fill    (wr_fill),
        .wr_addr    (wr_addr_q),
        .wr_data    (bus.up_data),
        .rd_en      (rd_en),
        .rd_release (rd_release),
        .rd_addr    (rd_addr_s),
        .rd_data    (rd_data),
        .full_wr    (full_wr),
        .full_rd    (full_rd)
    );

    assign bus.tx_valid   = tx_valid_q;
    assign bus.DATAOUT    = rd_data;
    assign bus.row_done   = row_done_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_row_stream_tx.sv
// Self-checking bench for row_stream_tx: every cycle's outputs are predicted
// from the accepted words and the burst-start / bank-occupancy rules.
module tb_row_stream_tx;
    import row_stream_tx_pkg::*;

    localparam int K   = 3;
    localparam int SW  = 8;
    localparam int WID = 8;
    localparam int GAP = 4;
    localparam int NR  = 3;
    localparam int W   = K * WID;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_stream_tx_if #(.W(W)) bus ();

    row_stream_tx #(
        .K          (K),
        .SRAM_WORD  (SW),
        .SRAM_WIDTH (WID),
        .GAP        (GAP),
        .NUM_ROWS   (NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           cyc;
    int           n_checks;
    int           n_errs;
    bit           m_run;
    logic [W-1:0] words[$];
    int           fill_cyc[$];
    int           start_cyc[$];
    logic [W-1:0] last_data;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict outputs for the current cycle from the row schedule.
    task automatic check_cycle();
        bit           ev, erd, efd;
        logic [W-1:0] ed;
        int           filled, released;
        ev = 1'b0; erd = 1'b0; efd = 1'b0; ed = last_data;
        filled = 0; released = 0;
        foreach (start_cyc[r]) begin
            if (cyc >= start_cyc[r] && cyc < start_cyc[r] + SW) begin
                ev = 1'b1;
                ed = words[r * SW + (cyc - start_cyc[r])];
            end
            if (cyc == start_cyc[r] + SW) begin
                erd = 1'b1;
                efd = ((r % NR) == NR - 1);
            end
            if (cyc >= start_cyc[r] + SW) released++;
        end
        foreach (fill_cyc[r]) begin
            if (fill_cyc[r] < cyc) filled++;
        end
        last_data = ed;
        chk("tx_valid", bus.tx_valid, W'(ev));
        chk("DATAOUT", bus.DATAOUT, ed);
        chk("row_done", bus.row_done, W'(erd));
        chk("frame_done", bus.frame_done, W'(efd));
        chk("up_ready", bus.up_ready, W'(m_run && (filled - released < 2)));
    endtask

    // Check mid-cycle, record any handshake, then advance one clock.
    task automatic step();
        int s;
        @(negedge clk);
        check_cycle();
        if (bus.up_valid && bus.up_ready) begin
            words.push_back(bus.up_data);
            if (words.size() % SW == 0) begin
                s = cyc + 2;
                if (start_cyc.size() > 0 && start_cyc[$] + SW + GAP + 1 > s)
                    s = start_cyc[$] + SW + GAP + 1;
                fill_cyc.push_back(cyc);
                start_cyc.push_back(s);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_run = !rst;
    endtask

    // mode 0: continuous, data = word index; 1: continuous random;
    // 2: valid every other cycle; 3: random valid.
    task automatic feed(input int n, input int mode);
        int target, budget;
        target = words.size() + n;
        budget = 0;
        while (words.size() < target && budget < 400) begin
            case (mode)
                0: begin bus.up_valid = 1'b1; bus.up_data = W'(words.size()); end
                1: begin bus.up_valid = 1'b1; bus.up_data = W'($urandom); end
                2: begin bus.up_valid = (budget % 2 == 0); bus.up_data = W'($urandom); end
                default: begin bus.up_valid = ($urandom_range(0, 2) != 0); bus.up_data = W'($urandom); end
            endcase
            step();
            budget++;
        end
        bus.up_valid = 1'b0;
        chk("feed_done", W'(words.size() >= target), W'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.up_valid = 1'b0;
            bus.up_data  = W'($urandom);
            step();
        end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errs = 0; m_run = 1'b0; last_data = '0;
        bus.up_valid = 1'b0;
        bus.up_data  = '0;
        #3;
        chk("rst_tx_valid", bus.tx_valid, '0);
        chk("rst_DATAOUT", bus.DATAOUT, '0);
        chk("rst_up_ready", bus.up_ready, '0);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Single row with data = word index.
        feed(SW, 0);
        idle(20);
        // Four back-to-back rows: both banks fill, frame wraps after the third.
        feed(4 * SW, 1);
        idle(30);
        // Gappy upstream.
        feed(2 * SW, 2);
        idle(30);
        // Random upstream valid.
        feed(3 * SW, 3);
        idle(40);

        // Reset at beat 3 of a burst.
        feed(SW, 1);
        while (cyc < start_cyc[$] + 3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", bus.tx_valid, '0);
        chk("mid_rst_DATAOUT", bus.DATAOUT, '0);
        chk("mid_rst_up_ready", bus.up_ready, '0);
        chk("mid_rst_row_done", bus.row_done, '0);
        words.delete();
        fill_cyc.delete();
        start_cyc.delete();
        last_data = '0;
        m_run = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        feed(SW, 0);
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/row_stream_tx.md
Name: row_stream_tx

Overview:
- Transmit side of the row-buffer input interface; it drives the K-pixel-wide `in_valid`/`DATAIN` stream that the row-buffer block consumes.
- Collects one full row of K-pixel column words from the Activation/Pooling output through a valid/ready handshake into a ping-pong row store.
- Replays each completed row as one gap-free burst of SRAM_WORD beats.
- Inserts the idle gap the row-buffer needs to return to its idle state before the next row.

Parameters:
- K, 3, pixels per column word (kernel height)
- SRAM_WORD, 256, beats per row burst (row length in columns)
- SRAM_WIDTH, 8, bits per pixel
- GAP, 4, minimum tx_valid-low cycles between bursts (1 idle-detect + 3 SRAM wait in the row-buffer)
- NUM_ROWS, 224, rows per frame

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- up_valid  in  1  upstream word valid
- up_data  in  K*SRAM_WIDTH  column word; pixel i in bits [i*SRAM_WIDTH +: SRAM_WIDTH]
- up_ready  out  1  write side can accept a word
- tx_valid  out  1  burst beat valid; connects to the row-buffer in_valid
- DATAOUT  out  K*SRAM_WIDTH  burst beat data; connects to the row-buffer DATAIN
- row_done  out  1  one-cycle pulse on the cycle after the last beat of a burst
- frame_done  out  1  one-cycle pulse coincident with row_done of row NUM_ROWS-1

Behaviour:
- Reset: all state is asynchronously cleared while rst=1.
  - tx_valid=0, DATAOUT=0, row_done=0, frame_done=0.
  - up_ready=0 while rst=1, then 1 from the first cycle after rst deasserts.
  - Banks empty; wr_bank=rd_bank=0; state IDLE.
  - Reset mid-row or mid-burst discards all partial data; no resumption.
- Storage: 2 banks × SRAM_WORD words × K*SRAM_WIDTH bits. Each bank has a full flag.
- Write side:
  - up_ready = !full[wr_bank].
  - Handshake (up_valid && up_ready) writes up_data to bank[wr_bank][wr_addr], then wr_addr++.
  - On the handshake with wr_addr==SRAM_WORD-1: full[wr_bank]<=1, wr_addr<=0, wr_bank toggles.
  - up_data is ignored when there is no handshake.
- Read FSM: IDLE, BURST, GAP.
  - IDLE: if full[rd_bank], go to BURST with rd_addr=0.
  - BURST:
    - tx_valid=1 on every cycle; DATAOUT=bank[rd_bank][rd_addr], registered; rd_addr++.
    - Exactly SRAM_WORD consecutive beats, with no stall and no backpressure.
    - After beat SRAM_WORD-1: full[rd_bank]<=0, rd_bank toggles, gap counter<=0, go to GAP.
  - GAP: tx_valid=0 and DATAOUT holds its last value for exactly GAP cycles, then IDLE.
- Latency:
  - If the last word of a row handshakes in cycle t, the first beat of that row appears in cycle t+2, provided the FSM is in IDLE.
  - Otherwise the first beat appears in the cycle after the FSM enters IDLE.
- Burst spacing: minimum start-to-start period is SRAM_WORD+GAP+1 cycles, which includes the IDLE detect cycle.
- Simultaneous events:
  - A write-side fill of one bank and a read-side release of the other bank in the same cycle both take effect.
  - The write side never targets a full bank, so set and clear never hit the same flag in the same cycle.
  - When both banks are full, up_ready=0 until the burst in progress releases its bank. up_ready rises in the cycle after that bank's last beat.
- Counting:
  - row_cnt increments on each row_done and wraps to 0 after NUM_ROWS-1.
  - frame_done is asserted alongside row_done when row_cnt==NUM_ROWS-1.
- Widths: address counters are $clog2(SRAM_WORD) bits; the gap counter is $clog2(GAP+1) bits; row_cnt is $clog2(NUM_ROWS) bits.

Decomposition:
- Shared package holds:
  - State encodings IDLE=2'd0, BURST=2'd1, GAP=2'd2.
  - The column word width K*SRAM_WIDTH.
  - The GAP default tied to the row-buffer's SRAM wait length (3) plus 1.
- Sub-module row_pingpong_store holds the two banks, the full flags, and the wr/rd bank pointers.
  - Its write port is addressed by wr_addr, its read port by rd_addr, with registered read data.
- The top level keeps the FSM, counters, and pulses.

Test Plan:
- Single row, K=3, SRAM_WORD=8, GAP=4; up_valid continuous with up_data=i for word i:
  - tx_valid is high for 8 consecutive cycles starting 2 cycles after the 8th handshake.
  - DATAOUT runs 0..7 in order; row_done fires once; tx_valid then stays low for at least 4 cycles.
- Back-to-back rows with upstream never stalling:
  - Bank 1 fills during burst 0.
  - Burst starts are exactly SRAM_WORD+GAP+1=13 cycles apart; data is correct per row.
- Both banks full: rows 0, 1 and part of row 2 are offered.
  - up_ready stays 0 from after row 1's last word until the cycle after burst 0's last beat.
  - No word is lost or duplicated.
- Frame wrap, NUM_ROWS=3, 4 rows sent:
  - frame_done pulses with the 3rd row_done only; row_cnt returns to 0; the 4th row streams normally.
- Reset mid-burst, rst=1 at beat 3 of 8:
  - tx_valid=0 and DATAOUT=0 immediately (asynchronous clear); up_ready=0 while rst=1, then 1 from the first cycle after release.
  - The next full row streams from word 0 with correct data.
- Gappy upstream (up_valid toggling every other cycle):
  - The burst does not start until all 8 words are stored, and it is still 8 contiguous beats.
